// File: rtl/pnr_photon_number_classifier.sv
// rtl/pnr_photon_number_classifier.sv - windowed ADC integrator and photon-number classifier; optional peak hold via PNR_PEAK_HOLD_EN
`timescale 1ns/1ps
module pnr_photon_number_classifier #(
   parameter int N_THR = 7,
   parameter int SUM_W = 32,
   parameter int WIN_W = 16
) (
   input  logic                   ADC_CLK,
   input  logic                   rstn_i,
   input  logic [13:0]            sig_i,
   input  logic                   delayed_trig_i,
   input  logic                   enable_i,
   input  logic [13:0]            baseline_i,
   input  logic [WIN_W-1:0]       win_len_i,
   input  logic [N_THR*SUM_W-1:0] thr_i,
   output logic                   busy_o,
   output logic                   pnr_valid_o,
   output logic [3:0]             pnr_number_o,
   output logic [SUM_W-1:0]       pnr_sum_o,
   output logic [14:0]            pnr_peak_o,
   output logic [31:0]            event_cnt_o,
   output logic [15:0]            missed_cnt_o
);

   typedef enum logic [1:0] {IDLE, INTEG, CLASSIFY, DONE} state_t;

   state_t                  state, state_nxt;
   logic signed [14:0]      d;
   logic signed [SUM_W-1:0] d_ext;
   logic [WIN_W-1:0]        w_eff;
   logic [WIN_W-1:0]        w_len;
   logic [WIN_W-1:0]        cnt;
   logic [WIN_W-1:0]        cnt_inc;
   logic signed [SUM_W-1:0] acc;
   logic signed [SUM_W-1:0] sum_hold;
   logic [N_THR-1:0]        ge;
   logic [N_THR-1:0]        ge_cmp;
   logic                    accept;
   logic                    miss;

   function automatic logic [3:0] popcount(input logic [N_THR-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int k = 0; k < N_THR; k++) begin
         n = n + {3'b000, v[k]};
      end
      return n;
   endfunction

   // 15-bit difference cannot overflow since both operands are 14-bit signed
   assign d       = $signed({sig_i[13], sig_i}) - $signed({baseline_i[13], baseline_i});
   assign d_ext   = $signed({{(SUM_W-15){d[14]}}, d});
   assign w_eff   = (win_len_i == '0) ? WIN_W'(1) : win_len_i;
   assign cnt_inc = cnt + WIN_W'(1);
   assign accept  = (state == IDLE) && delayed_trig_i && enable_i;
   assign miss    = (state != IDLE) && delayed_trig_i && enable_i;
   assign busy_o  = (state != IDLE);

   // signed compare of the finished integral against every threshold
   always_comb begin
      ge_cmp = '0;
      for (int k = 0; k < N_THR; k++) begin
         ge_cmp[k] = (acc >= $signed(thr_i[k*SUM_W +: SUM_W]));
      end
   end

   // state register
   always_ff @(posedge ADC_CLK or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: a one-sample window skips INTEG entirely
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (w_eff == WIN_W'(1)) ? CLASSIFY : INTEG;
            end
         end
         INTEG: begin
            if (cnt_inc == w_len) begin
               state_nxt = CLASSIFY;
            end
         end
         CLASSIFY: state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // integrator, compare stage and result registers
   always_ff @(posedge ADC_CLK or negedge rstn_i) begin
      if (!rstn_i) begin
         w_len        <= '0;
         cnt          <= '0;
         acc          <= '0;
         sum_hold     <= '0;
         ge           <= '0;
         pnr_valid_o  <= 1'b0;
         pnr_number_o <= '0;
         pnr_sum_o    <= '0;
      end else begin
         pnr_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  w_len <= w_eff;
                  acc   <= d_ext;
                  cnt   <= WIN_W'(1);
               end
            end
            INTEG: begin
               acc <= acc + d_ext;
               cnt <= cnt_inc;
            end
            CLASSIFY: begin
               ge       <= ge_cmp;
               sum_hold <= acc;
            end
            DONE: begin
               pnr_number_o <= popcount(ge);
               pnr_sum_o    <= sum_hold;
               pnr_valid_o  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // accepted-trigger counter wraps; missed counter saturates
   always_ff @(posedge ADC_CLK or negedge rstn_i) begin
      if (!rstn_i) begin
         event_cnt_o  <= '0;
         missed_cnt_o <= '0;
      end else begin
         if (accept) begin
            event_cnt_o <= event_cnt_o + 32'd1;
         end
         if (miss && (missed_cnt_o != 16'hFFFF)) begin
            missed_cnt_o <= missed_cnt_o + 16'd1;
         end
      end
   end

`ifdef PNR_PEAK_HOLD_EN
   logic signed [14:0] peak;
   logic signed [14:0] peak_hold;

   // running maximum of d, staged so it lands with the sum
   always_ff @(posedge ADC_CLK or negedge rstn_i) begin
      if (!rstn_i) begin
         peak       <= '0;
         peak_hold  <= '0;
         pnr_peak_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  peak <= d;
               end
            end
            INTEG: begin
               if (d > peak) begin
                  peak <= d;
               end
            end
            CLASSIFY: peak_hold  <= peak;
            DONE:     pnr_peak_o <= peak_hold;
            default: ;
         endcase
      end
   end
`else
   assign pnr_peak_o = '0;
`endif

endmodule

// File: tb/tb_pnr_photon_number_classifier.sv
// tb/tb_pnr_photon_number_classifier.sv - self-checking bench for pnr_photon_number_classifier
`timescale 1ns/1ps
module tb_pnr_photon_number_classifier;
   localparam int N_THR = 7;
   localparam int SUM_W = 32;
   localparam int WIN_W = 16;
`ifdef PNR_PEAK_HOLD_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic                   ADC_CLK = 1'b0;
   logic                   rstn_i;
   logic [13:0]            sig_i;
   logic                   delayed_trig_i;
   logic                   enable_i;
   logic [13:0]            baseline_i;
   logic [WIN_W-1:0]       win_len_i;
   logic [N_THR*SUM_W-1:0] thr_i;
   logic                   busy_o;
   logic                   pnr_valid_o;
   logic [3:0]             pnr_number_o;
   logic [SUM_W-1:0]       pnr_sum_o;
   logic [14:0]            pnr_peak_o;
   logic [31:0]            event_cnt_o;
   logic [15:0]            missed_cnt_o;

   pnr_photon_number_classifier #(.N_THR(N_THR), .SUM_W(SUM_W), .WIN_W(WIN_W)) dut (
      .ADC_CLK        (ADC_CLK),
      .rstn_i         (rstn_i),
      .sig_i          (sig_i),
      .delayed_trig_i (delayed_trig_i),
      .enable_i       (enable_i),
      .baseline_i     (baseline_i),
      .win_len_i      (win_len_i),
      .thr_i          (thr_i),
      .busy_o         (busy_o),
      .pnr_valid_o    (pnr_valid_o),
      .pnr_number_o   (pnr_number_o),
      .pnr_sum_o      (pnr_sum_o),
      .pnr_peak_o     (pnr_peak_o),
      .event_cnt_o    (event_cnt_o),
      .missed_cnt_o   (missed_cnt_o)
   );

   always #5 ADC_CLK = ~ADC_CLK;

   typedef struct {
      string  name;
      int     wcfg;
      int     base;
      int     sigv;
      int     thr0;
      int     step;
      longint exp_sum;
      int     exp_num;
   } vec_t;

   int  n_checks = 0;
   int  n_pass   = 0;
   int  samp [0:63];
   int  thr_v [0:N_THR-1];
   int  exp_ev   = 0;
   int  exp_miss = 0;
   vec_t tbl [0:5];

   function automatic vec_t mk(input string n, input int w, input int b, input int s,
                               input int t0, input int st, input longint es, input int en);
      vec_t v;
      v.name = n; v.wcfg = w; v.base = b; v.sigv = s;
      v.thr0 = t0; v.step = st; v.exp_sum = es; v.exp_num = en;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // reference model: plain arithmetic over the sample list
   function automatic longint ref_sum(input int weff, input int base);
      longint s = 0;
      for (int i = 0; i < weff; i++) s += longint'(samp[i] - base);
      return s;
   endfunction

   function automatic int ref_num(input longint s);
      int n = 0;
      for (int k = 0; k < N_THR; k++) if (s >= longint'(thr_v[k])) n++;
      return n;
   endfunction

   function automatic int ref_peak(input int weff, input int base);
      int p = samp[0] - base;
      for (int i = 1; i < weff; i++) if (samp[i] - base > p) p = samp[i] - base;
      return p;
   endfunction

   task automatic apply_thr();
      for (int k = 0; k < N_THR; k++) thr_i[k*SUM_W +: SUM_W] = thr_v[k];
   endtask

   // called at a negedge in IDLE; returns at the negedge of the valid cycle
   task automatic run_window(input string name, input int wcfg, input int base,
                             output longint got_sum, output int got_num, output int got_peak);
      int     weff;
      longint es;
      int     en;
      int     ep;
      bit     busy_ok;
      bit     valid_ok;
      weff = (wcfg == 0) ? 1 : wcfg;
      es   = ref_sum(weff, base);
      en   = ref_num(es);
      ep   = PEAK_EN ? ref_peak(weff, base) : 0;
      apply_thr();
      baseline_i     = 14'(base);
      win_len_i      = WIN_W'(wcfg);
      enable_i       = 1'b1;
      busy_ok        = (busy_o == 1'b0);
      valid_ok       = (pnr_valid_o == 1'b0);
      delayed_trig_i = 1'b1;
      sig_i          = 14'(samp[0]);
      for (int j = 1; j <= weff + 2; j++) begin
         @(negedge ADC_CLK);
         delayed_trig_i = 1'b0;
         sig_i = (j < weff) ? 14'(samp[j]) : 14'($urandom);
         if (busy_o !== (j <= weff + 1)) busy_ok = 1'b0;
         if (pnr_valid_o !== (j == weff + 2)) valid_ok = 1'b0;
      end
      exp_ev++;
      got_sum  = longint'($signed(pnr_sum_o));
      got_num  = int'(pnr_number_o);
      got_peak = int'($signed(pnr_peak_o));
      chk({name, " busy_window"}, longint'(busy_ok), 1);
      chk({name, " valid_timing"}, longint'(valid_ok), 1);
      chk({name, " sum"}, got_sum, es);
      chk({name, " number"}, longint'(got_num), longint'(en));
      chk({name, " peak"}, longint'(got_peak), longint'(ep));
      chk({name, " event_cnt"}, longint'(event_cnt_o), longint'(exp_ev));
   endtask

   task automatic check_all_zero(input string name);
      chk({name, " busy"},   longint'(busy_o), 0);
      chk({name, " valid"},  longint'(pnr_valid_o), 0);
      chk({name, " number"}, longint'(pnr_number_o), 0);
      chk({name, " sum"},    longint'(pnr_sum_o), 0);
      chk({name, " peak"},   longint'(pnr_peak_o), 0);
      chk({name, " events"}, longint'(event_cnt_o), 0);
      chk({name, " missed"}, longint'(missed_cnt_o), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint gs;
      int     gn;
      int     gp;
      bit     seen;

      rstn_i = 1'b0; sig_i = '0; delayed_trig_i = 1'b0; enable_i = 1'b0;
      baseline_i = '0; win_len_i = '0; thr_i = '0;
      repeat (3) @(negedge ADC_CLK);
      check_all_zero("reset");
      rstn_i = 1'b1;
      @(negedge ADC_CLK);

      // table-driven vectors with constant samples
      tbl[0] = mk("w4_const",     4,   100,   300,     0, 200,    800, 5);
      tbl[1] = mk("w0_as_w1",     0,   -20,    30,     0,   0,     50, 7);
      tbl[2] = mk("neg_thr_miss", 2,     0, -1000, -1500,   0,  -2000, 0);
      tbl[3] = mk("neg_thr_eq",   2,     0, -1000, -2000,   0,  -2000, 1);
      tbl[4] = mk("w1_zero",      1,   555,   555,     0,   1,      0, 1);
      tbl[5] = mk("max_neg_d",    3,  8191, -8192, -49149, 0, -49149, 1);
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 64; i++) samp[i] = tbl[t].sigv;
         thr_v[0] = tbl[t].thr0;
         for (int k = 1; k < N_THR; k++) thr_v[k] = k * tbl[t].step;
         run_window(tbl[t].name, tbl[t].wcfg, tbl[t].base, gs, gn, gp);
         chk({tbl[t].name, " table_sum"}, gs, tbl[t].exp_sum);
         chk({tbl[t].name, " table_number"}, longint'(gn), longint'(tbl[t].exp_num));
         @(negedge ADC_CLK);
      end

      // peak of d = 5,40,-3,12
      samp[0] = 5; samp[1] = 40; samp[2] = -3; samp[3] = 12;
      for (int k = 0; k < N_THR; k++) thr_v[k] = 10 * k;
      run_window("peak_seq", 4, 0, gs, gn, gp);
      chk("peak_seq const_sum", gs, 54);
      chk("peak_seq const_peak", longint'(gp), PEAK_EN ? 40 : 0);
      @(negedge ADC_CLK);

      // trigger while busy is missed; trigger on the valid cycle is accepted
      for (int i = 0; i < 64; i++) samp[i] = 10;
      for (int k = 0; k < N_THR; k++) thr_v[k] = 20 * k;
      apply_thr();
      baseline_i = '0; win_len_i = 16'd8; enable_i = 1'b1;
      delayed_trig_i = 1'b1; sig_i = 14'd10;
      for (int j = 1; j <= 10; j++) begin
         @(negedge ADC_CLK);
         delayed_trig_i = (j == 2) || (j == 10);
      end
      exp_ev++; exp_miss++;
      chk("busy_trig valid_at_T+10", longint'(pnr_valid_o), 1);
      chk("busy_trig sum", longint'($signed(pnr_sum_o)), 80);
      chk("busy_trig number", longint'(pnr_number_o), 5);
      chk("busy_trig events_before", longint'(event_cnt_o), longint'(exp_ev));
      chk("busy_trig missed", longint'(missed_cnt_o), longint'(exp_miss));
      @(negedge ADC_CLK);
      delayed_trig_i = 1'b0;
      exp_ev++;
      chk("valid_cycle_trig busy", longint'(busy_o), 1);
      chk("valid_cycle_trig events", longint'(event_cnt_o), longint'(exp_ev));
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge ADC_CLK);
         if (pnr_valid_o) seen = 1'b1;
      end
      chk("valid_cycle_trig result_seen", longint'(seen), 1);
      chk("valid_cycle_trig sum", longint'($signed(pnr_sum_o)), 80);
      @(negedge ADC_CLK);

      // enable low: triggers neither accepted nor missed; drop mid-window still reports
      enable_i = 1'b0; delayed_trig_i = 1'b1;
      @(negedge ADC_CLK);
      delayed_trig_i = 1'b0;
      chk("disabled busy", longint'(busy_o), 0);
      chk("disabled events", longint'(event_cnt_o), longint'(exp_ev));
      enable_i = 1'b1; win_len_i = 16'd3; delayed_trig_i = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         @(negedge ADC_CLK);
         enable_i = 1'b0;
         delayed_trig_i = (j == 2);
      end
      exp_ev++;
      chk("en_drop valid", longint'(pnr_valid_o), 1);
      chk("en_drop sum", longint'($signed(pnr_sum_o)), 30);
      chk("en_drop missed", longint'(missed_cnt_o), longint'(exp_miss));
      chk("en_drop events", longint'(event_cnt_o), longint'(exp_ev));
      @(negedge ADC_CLK);

      // reset mid-window aborts with no valid
      enable_i = 1'b1; win_len_i = 16'd16; delayed_trig_i = 1'b1;
      @(negedge ADC_CLK);
      delayed_trig_i = 1'b0;
      @(negedge ADC_CLK);
      rstn_i = 1'b0;
      #1;
      exp_ev = 0; exp_miss = 0;
      check_all_zero("mid_reset");
      @(negedge ADC_CLK);
      rstn_i = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge ADC_CLK);
         if (pnr_valid_o) seen = 1'b1;
      end
      chk("mid_reset no_valid", longint'(seen), 0);
      for (int i = 0; i < 64; i++) samp[i] = 300;
      for (int k = 0; k < N_THR; k++) thr_v[k] = 200 * k;
      run_window("after_reset", 4, 100, gs, gn, gp);
      @(negedge ADC_CLK);

      // randomized windows against the reference model
      for (int r = 0; r < 20; r++) begin
         int     w;
         int     b;
         longint s;
         w = $urandom_range(1, 12);
         b = int'($urandom_range(0, 4000)) - 2000;
         for (int i = 0; i < 64; i++) samp[i] = int'($urandom_range(0, 16383)) - 8192;
         s = ref_sum(w, b);
         for (int k = 0; k < N_THR; k++)
            thr_v[k] = (k == r % N_THR) ? int'(s) : int'(s) + int'($urandom_range(0, 400)) - 200;
         run_window($sformatf("rand%0d", r), (w == 1 && r[0]) ? 0 : w, b, gs, gn, gp);
         @(negedge ADC_CLK);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
